// File: rtl/array_4_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// array_4_ctrl_pkg
// Shared types and constants for the array_4 SRAM sequencer/arbiter:
//   - geometry of the 256x24 masked single-port SRAM macro
//   - controller state encoding (INIT / IDLE)
//   - write request bundle (addr, data, mask)
// No ports; imported by the interface, the arbiter and the top.
// -----------------------------------------------------------------------------
package array_4_ctrl_pkg;

    localparam int ADDR_W   = 32'd8;
    localparam int DATA_W   = 32'd24;
    localparam int MASK_SEG = 32'd2;
    localparam int SEG_W    = DATA_W / MASK_SEG;
    localparam int DEPTH    = 32'd1 << ADDR_W;

    localparam logic [DATA_W-1:0] INIT_VALUE_DEF = 24'h000000;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [MASK_SEG-1:0] mask;
    } req_t;

    // Write mask that enables every segment of a word.
    function automatic logic [MASK_SEG-1:0] full_mask();
        full_mask = {MASK_SEG{1'b1}};
    endfunction

endpackage

// File: rtl/array_4_ctrl_if.sv
// -----------------------------------------------------------------------------
// array_4_ctrl_if
// Requester-side bus of the array_4 controller.
//   write channel : w_valid / w_ready / w_addr / w_data / w_mask
//   read channel  : r_valid / r_ready / r_addr
//   read response : resp_valid / resp_data (no backpressure)
// Modports:
//   master - the table logic issuing requests
//   slave  - the controller (array_4_ctrl)
// -----------------------------------------------------------------------------
interface array_4_ctrl_if;
    import array_4_ctrl_pkg::*;

    logic                w_valid;
    logic                w_ready;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [MASK_SEG-1:0] w_mask;

    logic                r_valid;
    logic                r_ready;
    logic [ADDR_W-1:0]   r_addr;

    logic                resp_valid;
    logic [DATA_W-1:0]   resp_data;

    modport master (
        output w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
        input  w_ready, r_ready, resp_valid, resp_data
    );

    modport slave (
        input  w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
        output w_ready, r_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/array_4_rr_arb.sv
// -----------------------------------------------------------------------------
// array_4_rr_arb
// Two-way round-robin arbiter (write vs. read) with a single priority flop.
// Ports:
//   clock, reset_n  - clock and synchronous active-low reset
//   arb_en          - arbitration allowed this cycle (init done, no flush)
//   w_req, r_req    - request valids
//   w_rdy, r_rdy    - ready terms presented to the requesters
//   w_gnt, r_gnt    - resulting grants (valid && ready)
// The priority only moves on a conflict grant, so a lone requester never
// steals the next conflict turn from the other side.
// -----------------------------------------------------------------------------
module array_4_rr_arb (
    input  logic clock,
    input  logic reset_n,
    input  logic arb_en,
    input  logic w_req,
    input  logic r_req,
    output logic w_rdy,
    output logic r_rdy,
    output logic w_gnt,
    output logic r_gnt
);

    logic prio_write_r;

    // Ready is independent of the requester's own valid; it only depends on
    // whether the other side is competing and whose turn it is.
    always_comb begin
        w_rdy = arb_en && (!r_req || prio_write_r);
        r_rdy = arb_en && (!w_req || !prio_write_r);
        w_gnt = w_req && w_rdy;
        r_gnt = r_req && r_rdy;
    end

    // Priority flop: starts with write, toggles after every conflict grant.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prio_write_r <= 1'b1;
        end else if (arb_en && w_req && r_req) begin
            prio_write_r <= !prio_write_r;
        end else begin
            prio_write_r <= prio_write_r;
        end
    end

endmodule

// File: rtl/array_4_ctrl.sv
// -----------------------------------------------------------------------------
// array_4_ctrl
// Sequencer and arbiter in front of a 256x24 single-port masked SRAM macro
// (read data valid one cycle after a read enable).
// After reset or a flush the whole array is written with INIT_VALUE, one word
// per cycle; afterwards the single RW port is shared between one write and
// one read requester with round-robin arbitration.
// Ports:
//   clock, reset_n  - clock and synchronous active-low reset
//   flush           - pulse: re-initialize the whole array
//   init_done       - high once init is complete and requests are served
//   bus             - requester bus (write, read, read response)
//   sram_en/wmode/addr/wmask/wdata - SRAM command (wmode 1 = write)
//   sram_rdata      - SRAM read data, forwarded as resp_data
// -----------------------------------------------------------------------------
module array_4_ctrl
    import array_4_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE = INIT_VALUE_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    output logic                init_done,
    array_4_ctrl_if.slave       bus,
    output logic                sram_en,
    output logic                sram_wmode,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [MASK_SEG-1:0] sram_wmask,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam logic [0:0]        ST_INIT   = INIT;
    localparam logic [0:0]        ST_IDLE   = IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] init_cnt_r;
    logic              init_done_r;
    logic              resp_valid_r;

    logic              arb_en_s;
    logic              w_rdy_s;
    logic              r_rdy_s;
    logic              w_gnt_s;
    logic              r_gnt_s;
    req_t              wr_req_s;

    assign wr_req_s.addr = bus.w_addr;
    assign wr_req_s.data = bus.w_data;
    assign wr_req_s.mask = bus.w_mask;

    // A flush blocks any grant in the same cycle it is seen.
    assign arb_en_s = init_done_r && !flush;

    array_4_rr_arb u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .arb_en  (arb_en_s),
        .w_req   (bus.w_valid),
        .r_req   (bus.r_valid),
        .w_rdy   (w_rdy_s),
        .r_rdy   (r_rdy_s),
        .w_gnt   (w_gnt_s),
        .r_gnt   (r_gnt_s)
    );

    assign bus.w_ready    = w_rdy_s;
    assign bus.r_ready    = r_rdy_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = sram_rdata;
    assign init_done      = init_done_r;

    // FSM, init counter and read-response pipeline.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= ST_INIT;
            init_cnt_r   <= '0;
            init_done_r  <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            // A read granted in a flush's previous cycle still answers.
            resp_valid_r <= r_gnt_s;
            case (state_r)
                ST_INIT: begin
                    if (flush) begin
                        init_cnt_r <= '0;
                    end else if (init_cnt_r == LAST_ADDR) begin
                        state_r     <= ST_IDLE;
                        init_done_r <= 1'b1;
                        init_cnt_r  <= '0;
                    end else begin
                        init_cnt_r <= init_cnt_r + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (flush) begin
                        state_r     <= ST_INIT;
                        init_cnt_r  <= '0;
                        init_done_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_cnt_r  <= '0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // SRAM command mux: init sweep, write grant, read grant or idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        case (state_r)
            ST_INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = init_cnt_r;
                sram_wmask = full_mask();
                sram_wdata = INIT_VALUE;
            end
            ST_IDLE: begin
                if (w_gnt_s) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = wr_req_s.addr;
                    sram_wmask = wr_req_s.mask;
                    sram_wdata = wr_req_s.data;
                end else if (r_gnt_s) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b0;
                    sram_addr  = bus.r_addr;
                end else begin
                    sram_en    = 1'b0;
                end
            end
            default: begin
                sram_en = 1'b0;
            end
        endcase
    end

endmodule
